// File: rtl/gate_lab_pkg.sv
// Shared definitions for the two-input gate lab: checker FSM state encoding
// and reference truth tables for the common two-input gates.
package gate_lab_pkg;

  // Checker FSM encoding (IDLE=0, SETTLE=1, SAMPLE=2)
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2
  } chk_state_e;

  typedef enum logic [2:0] {
    GATE_NOR  = 3'd0,
    GATE_NAND = 3'd1,
    GATE_AND  = 3'd2,
    GATE_OR   = 3'd3,
    GATE_XOR  = 3'd4
  } gate_e;

  localparam int unsigned SETTLE_CNT_W = 4;

  // Truth table for a two-input gate; bit k is the output for input value k
  function automatic logic [3:0] gate_truth(input gate_e g);
    logic [3:0] t;
    case (g)
      GATE_NOR:  t = 4'b0001;
      GATE_NAND: t = 4'b0111;
      GATE_AND:  t = 4'b1000;
      GATE_OR:   t = 4'b1110;
      GATE_XOR:  t = 4'b0110;
      default:   t = 4'b0000;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, or step unless already at the maximum value
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/truth_table_checker.sv
// Response checker for combinational gate labs: accepts stimulus vectors,
// drives them to the gate, waits SETTLE cycles, then compares the gate output
// against TRUTH. Tracks pass/fail counts, first failing vector and coverage.
// Optional build macro TRUTH_TABLE_CHECKER_ERR_IRQ_EN adds the err_irq pulse.
//
// Handshake: a vector transfers on a rising edge where vec_valid and
// vec_ready are both 1; vec_ready is high only in IDLE with start low, and
// the upstream holds vec_data stable while vec_valid is high and unaccepted.
module truth_table_checker
  import gate_lab_pkg::*;
#(
  parameter int                    N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0]  TRUTH  = gate_truth(GATE_NOR),
  parameter int                    SETTLE = 2,
  parameter int                    CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  vec_valid,
  input  logic [N_IN-1:0]       vec_data,
  output logic                  vec_ready,
  output logic [N_IN-1:0]       dut_in,
  input  logic                  dut_q,
  output logic [CNT_W-1:0]      pass_cnt,
  output logic [CNT_W-1:0]      fail_cnt,
  output logic                  first_fail_vld,
  output logic [N_IN-1:0]       first_fail_vec,
  output logic [(1<<N_IN)-1:0]  covered,
`ifdef TRUTH_TABLE_CHECKER_ERR_IRQ_EN
  output logic                  err_irq,
`endif
  output logic                  done
);

  localparam int NV = 1 << N_IN;

  chk_state_e              state_q, state_d;
  logic [SETTLE_CNT_W-1:0] settle_q, settle_d;
  logic [N_IN-1:0]         dut_in_q, dut_in_d;
  logic [NV-1:0]           covered_q, covered_d;
  logic                    done_q, done_d;
  logic                    ff_vld_q, ff_vld_d;
  logic [N_IN-1:0]         ff_vec_q, ff_vec_d;
  logic                    pass_inc, fail_inc;
  logic                    mismatch;
`ifdef TRUTH_TABLE_CHECKER_ERR_IRQ_EN
  logic                    err_irq_q, err_irq_d;
`endif

  assign mismatch = (dut_q != TRUTH[dut_in_q]);

  // FSM next state, handshake, settle timer, scoring, coverage and capture
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    dut_in_d  = dut_in_q;
    covered_d = covered_q;
    done_d    = done_q;
    ff_vld_d  = ff_vld_q;
    ff_vec_d  = ff_vec_q;
    pass_inc  = 1'b0;
    fail_inc  = 1'b0;
    vec_ready = 1'b0;
`ifdef TRUTH_TABLE_CHECKER_ERR_IRQ_EN
    err_irq_d = 1'b0;
`endif
    if (start) begin
      // Abandon any check in flight; dut_in keeps its last value
      state_d   = ST_IDLE;
      settle_d  = '0;
      covered_d = '0;
      done_d    = 1'b0;
      ff_vld_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          vec_ready = 1'b1;
          if (vec_valid) begin
            dut_in_d = vec_data;
            settle_d = SETTLE_CNT_W'(SETTLE - 1);
            state_d  = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_q == '0) begin
            state_d = ST_SAMPLE;
          end else begin
            settle_d = settle_q - 1'b1;
          end
        end
        ST_SAMPLE: begin
          pass_inc = ~mismatch;
          fail_inc = mismatch;
          if (mismatch && !ff_vld_q) begin
            ff_vld_d = 1'b1;
            ff_vec_d = dut_in_q;
          end
`ifdef TRUTH_TABLE_CHECKER_ERR_IRQ_EN
          err_irq_d = mismatch;
`endif
          covered_d[dut_in_q] = 1'b1;
          done_d  = &covered_d;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, stimulus and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      settle_q  <= '0;
      dut_in_q  <= '0;
      covered_q <= '0;
      done_q    <= 1'b0;
      ff_vld_q  <= 1'b0;
      ff_vec_q  <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      dut_in_q  <= dut_in_d;
      covered_q <= covered_d;
      done_q    <= done_d;
      ff_vld_q  <= ff_vld_d;
      ff_vec_q  <= ff_vec_d;
    end
  end

`ifdef TRUTH_TABLE_CHECKER_ERR_IRQ_EN
  // Mismatch pulse, one cycle after the failing sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_irq_q <= 1'b0;
    end else begin
      err_irq_q <= err_irq_d;
    end
  end

  assign err_irq = err_irq_q;
`endif

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pass_inc),
    .clr   (start),
    .cnt   (pass_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fail_inc),
    .clr   (start),
    .cnt   (fail_cnt)
  );

  assign dut_in         = dut_in_q;
  assign covered        = covered_q;
  assign done           = done_q;
  assign first_fail_vld = ff_vld_q;
  assign first_fail_vec = ff_vec_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker with a NOR gate model (good,
// stuck-at-0 or inverted). A second instance with CNT_W=2 shares the stimulus
// to observe counter saturation.
module tb_truth_table_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       vec_valid = 1'b0;
  logic [1:0] vec_data = 2'b00;
  logic       vec_ready, vec_ready2;
  logic [1:0] dut_in, dut_in2;
  logic       dut_q;
  logic [7:0] pass_cnt, fail_cnt;
  logic [1:0] pass_cnt2, fail_cnt2;
  logic       ff_vld, ff_vld2;
  logic [1:0] ff_vec, ff_vec2;
  logic [3:0] covered, covered2;
  logic       done, done2;
`ifdef TRUTH_TABLE_CHECKER_ERR_IRQ_EN
  logic       err_irq, err_irq2;
  int         irq_pulses = 0;
`endif

  int         gate_mode = 0;  // 0 good NOR, 1 stuck at 0, 2 inverted (OR)
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  int         acc_t[4];

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef TRUTH_TABLE_CHECKER_ERR_IRQ_EN
  always @(posedge clk) if (err_irq) irq_pulses <= irq_pulses + 1;
`endif

  // Gate under lab
  assign dut_q = (gate_mode == 1) ? 1'b0 :
                 (gate_mode == 2) ? (dut_in[1] | dut_in[0]) :
                                    ~(dut_in[1] | dut_in[0]);

  truth_table_checker u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .vec_valid      (vec_valid),
    .vec_data       (vec_data),
    .vec_ready      (vec_ready),
    .dut_in         (dut_in),
    .dut_q          (dut_q),
    .pass_cnt       (pass_cnt),
    .fail_cnt       (fail_cnt),
    .first_fail_vld (ff_vld),
    .first_fail_vec (ff_vec),
    .covered        (covered),
`ifdef TRUTH_TABLE_CHECKER_ERR_IRQ_EN
    .err_irq        (err_irq),
`endif
    .done           (done)
  );

  truth_table_checker #(.CNT_W(2)) u_dut_sat (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .vec_valid      (vec_valid),
    .vec_data       (vec_data),
    .vec_ready      (vec_ready2),
    .dut_in         (dut_in2),
    .dut_q          (dut_q),
    .pass_cnt       (pass_cnt2),
    .fail_cnt       (fail_cnt2),
    .first_fail_vld (ff_vld2),
    .first_fail_vec (ff_vec2),
    .covered        (covered2),
`ifdef TRUTH_TABLE_CHECKER_ERR_IRQ_EN
    .err_irq        (err_irq2),
`endif
    .done           (done2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer a vector and return at the negedge before the accepting edge
  task automatic send_vec(input logic [1:0] v);
    int n;
    n = 0;
    @(negedge clk);
    vec_valid = 1'b1;
    vec_data  = v;
    while (!vec_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!vec_ready) check_eq("accept_timeout", 32'(n), 32'(0));
    acc_t[0] = acc_t[1];
    acc_t[1] = acc_t[2];
    acc_t[2] = acc_t[3];
    acc_t[3] = cyc;
  endtask

  task automatic drain();
    @(negedge clk);
    vec_valid = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    // Reset values
    #12;
    check_eq("rst_ready", 32'(vec_ready), 32'(1));
    check_eq("rst_pass", 32'(pass_cnt), 32'(0));
    check_eq("rst_fail", 32'(fail_cnt), 32'(0));
    check_eq("rst_cov", 32'(covered), 32'(0));
    check_eq("rst_done", 32'(done), 32'(0));
    check_eq("rst_ffvld", 32'(ff_vld), 32'(0));
    check_eq("rst_dutin", 32'(dut_in), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Good NOR, all four vectors back to back
    gate_mode = 0;
    pulse_start();
    send_vec(2'b00);
    send_vec(2'b01);
    send_vec(2'b10);
    send_vec(2'b11);
    check_eq("gap_01", 32'(acc_t[1] - acc_t[0]), 32'(4));
    check_eq("gap_12", 32'(acc_t[2] - acc_t[1]), 32'(4));
    check_eq("gap_23", 32'(acc_t[3] - acc_t[2]), 32'(4));
    drain();
    check_eq("nor_pass", 32'(pass_cnt), 32'(4));
    check_eq("nor_fail", 32'(fail_cnt), 32'(0));
    check_eq("nor_cov", 32'(covered), 32'hf);
    check_eq("nor_done", 32'(done), 32'(1));
    check_eq("nor_ffvld", 32'(ff_vld), 32'(0));
    check_eq("nor_dutin_hold", 32'(dut_in), 32'(3));

    // Stuck-at-0 gate
    pulse_start();
    check_eq("start_done_clr", 32'(done), 32'(0));
`ifdef TRUTH_TABLE_CHECKER_ERR_IRQ_EN
    irq_pulses = 0;
`endif
    gate_mode = 1;
    send_vec(2'b00);
    send_vec(2'b01);
    send_vec(2'b10);
    send_vec(2'b11);
    drain();
    check_eq("sa0_pass", 32'(pass_cnt), 32'(3));
    check_eq("sa0_fail", 32'(fail_cnt), 32'(1));
    check_eq("sa0_ffvld", 32'(ff_vld), 32'(1));
    check_eq("sa0_ffvec", 32'(ff_vec), 32'(0));
    check_eq("sa0_done", 32'(done), 32'(1));
`ifdef TRUTH_TABLE_CHECKER_ERR_IRQ_EN
    check_eq("sa0_irq", 32'(irq_pulses), 32'(1));
`endif
    // A later mismatch must not overwrite the first capture
    gate_mode = 2;
    send_vec(2'b11);
    drain();
    check_eq("inv_fail", 32'(fail_cnt), 32'(2));
    check_eq("inv_ffvec", 32'(ff_vec), 32'(0));
    check_eq("inv_done_hold", 32'(done), 32'(1));

    // Repeated vectors
    gate_mode = 0;
    pulse_start();
    send_vec(2'b01);
    send_vec(2'b01);
    send_vec(2'b01);
    send_vec(2'b11);
    drain();
    check_eq("rep_pass", 32'(pass_cnt), 32'(4));
    check_eq("rep_cov", 32'(covered), 32'ha);
    check_eq("rep_done", 32'(done), 32'(0));

    // start during SETTLE of the second vector
    pulse_start();
    send_vec(2'b00);
    send_vec(2'b01);
    @(negedge clk);
    check_eq("mid_pass_before", 32'(pass_cnt), 32'(1));
    start = 1'b1;
    #1;
    check_eq("start_ready_low", 32'(vec_ready), 32'(0));
    @(negedge clk);
    start = 1'b0;
    vec_valid = 1'b0;
    #1;
    check_eq("start_ready_high", 32'(vec_ready), 32'(1));
    check_eq("start_pass_clr", 32'(pass_cnt), 32'(0));
    check_eq("start_cov_clr", 32'(covered), 32'(0));
    drain();
    check_eq("start_pass_after", 32'(pass_cnt), 32'(0));
    check_eq("start_fail_after", 32'(fail_cnt), 32'(0));
    check_eq("start_cov_after", 32'(covered), 32'(0));

    // Saturation on the CNT_W=2 instance
    pulse_start();
    send_vec(2'b00);
    send_vec(2'b01);
    send_vec(2'b10);
    send_vec(2'b11);
    send_vec(2'b00);
    drain();
    check_eq("sat_pass8", 32'(pass_cnt), 32'(5));
    check_eq("sat_pass2", 32'(pass_cnt2), 32'(3));
    check_eq("sat_fail2", 32'(fail_cnt2), 32'(0));

    // Async reset during SETTLE
    send_vec(2'b10);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("arst_ready", 32'(vec_ready), 32'(1));
    check_eq("arst_pass", 32'(pass_cnt), 32'(0));
    check_eq("arst_cov", 32'(covered), 32'(0));
    check_eq("arst_done", 32'(done), 32'(0));
    check_eq("arst_dutin", 32'(dut_in), 32'(0));
    vec_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("arst_pass_after", 32'(pass_cnt), 32'(0));
    check_eq("arst_fail_after", 32'(fail_cnt), 32'(0));
    check_eq("arst_cov_after", 32'(covered), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Response end of the gate-level stimulus stream used for two-input gate labs (e.g. the NOR-from-NAND gate).
- Accepts input vectors over a valid/ready handshake and drives them to a combinational DUT.
- After a settle delay, samples the DUT output and compares it against a parameterised truth table.
- Counts passes and fails, records the first failing vector, tracks coverage of all 2^N_IN input combinations, and flags done once every combination has been checked.

Parameters:
- N_IN, 2, number of DUT inputs (1..4).
- TRUTH, 4'b0001, expected DUT output indexed by input vector; bit k is the expected Q for vector value k. Width is 2^N_IN. The default is NOR.
- SETTLE, 2, clock cycles between driving dut_in and sampling dut_q (1..15).
- CNT_W, 8, width of the pass and fail counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; clears counters, coverage and first-fail capture.
- vec_valid  in  1  stimulus vector valid.
- vec_data  in  N_IN  stimulus vector.
- vec_ready  out  1  checker can accept a vector.
- dut_in  out  N_IN  vector driven to the DUT.
- dut_q  in  1  DUT output.
- pass_cnt  out  CNT_W  number of matching checks.
- fail_cnt  out  CNT_W  number of mismatching checks.
- first_fail_vld  out  1  a mismatch has been captured.
- first_fail_vec  out  N_IN  vector of the first mismatch.
- covered  out  2^N_IN  bitmap of vectors checked since start.
- done  out  1  all bits of covered are set.

Behaviour:
- Reset:
  - Every output is 0 except vec_ready, which is 1.
  - FSM goes to IDLE; the settle counter is 0.
- FSM states: IDLE, SETTLE, SAMPLE.
- IDLE:
  - vec_ready = 1.
  - On vec_valid & vec_ready: latch vec_data into dut_in (dut_in is registered), load the settle counter with SETTLE-1, go to SETTLE.
- SETTLE:
  - vec_ready = 0.
  - The counter decrements each cycle; go to SAMPLE when it is 0.
  - Result: the sample takes place exactly SETTLE cycles after the cycle in which dut_in updates.
- SAMPLE (one cycle):
  - vec_ready = 0.
  - Compare dut_q with TRUTH[dut_in].
  - Match: pass_cnt++. Mismatch: fail_cnt++.
  - Set covered[dut_in]. Return to IDLE.
  - Throughput: one vector per SETTLE+2 cycles.
- First-fail capture:
  - On the first mismatch after start/reset: first_fail_vld = 1 and first_fail_vec = dut_in.
  - Later mismatches do not overwrite the capture.
- Counters saturate at 2^CNT_W-1 and never wrap.
- done is registered and goes high in the cycle after the SAMPLE that sets the last covered bit.
- Repeated vectors are checked and counted again but do not change coverage. done stays high until start or reset.
- dut_in holds its value between vectors; it is not returned to 0.
- start:
  - In any state, start takes priority. It clears pass_cnt, fail_cnt, covered, done and first_fail_vld and forces IDLE; dut_in is held.
  - A vector offered in the same cycle as start is not accepted (vec_ready is forced to 0 that cycle).
  - A check in progress when start arrives is abandoned and not counted.
- Async reset mid-check: all state returns to reset values immediately; no partial count is recorded.
- vec_valid may rise while vec_ready = 0; the vector is held upstream and accepted on the next IDLE cycle.

Optional Feature:
- Macro: TRUTH_TABLE_CHECKER_ERR_IRQ_EN.
- Defined: adds output err_irq (1 bit), a single-cycle pulse in the cycle after any SAMPLE that mismatches. Its reset value is 0.
- Undefined: the port is absent and there is no logic for it; all other behaviour is identical.

Decomposition:
- Shared package (gate_lab_pkg):
  - FSM state encoding constants: IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2.
  - Function returning the default NOR/NAND/AND/OR/XOR truth-table constants for N_IN=2.
- Sub-module sat_counter (parameter W; inputs inc and clr; output cnt), instantiated twice for pass_cnt and fail_cnt.
- FSM, settle counter, coverage and capture logic stay in truth_table_checker.

Test Plan:
- Correct NOR DUT, default parameters: send vectors 00, 01, 10, 11 back-to-back with vec_valid held high. Required: pass_cnt=4, fail_cnt=0, covered=4'b1111, done=1, first_fail_vld=0; each vector is accepted every 4 cycles.
- DUT with dut_q stuck at 0: same sequence. Required: pass_cnt=3, fail_cnt=1, first_fail_vld=1, first_fail_vec=2'b00, done=1. With the macro defined, err_irq pulses exactly once.
- Repeats: send 01 three times, then 11. Required: pass_cnt=4, covered=4'b1010, done=0.
- start asserted during SETTLE of the second vector. Required: counters and covered are 0; the second vector is not counted; vec_ready=1 on the cycle after start.
- CNT_W=2: send 5 correct vectors. Required: pass_cnt saturates at 3.
- rst_n asserted low mid-SETTLE. Required: all outputs are at reset values immediately (asynchronously), vec_ready=1, and there is no sample after release.
